mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multicycle main control FSM for one MIPS core; sits directly upstream of the ALU control block.
- Drives the 2-bit ALU-op code that the ALU control block consumes, plus all datapath and memory strobes.
- Memory-phase states hold on a per-core mem_ready handshake, so shared-memory arbitration in the quad-core stalls cleanly.

Parameters:
- None. State encoding and opcodes come from the shared package.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26]; stable from DECODE until return to FETCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs it)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back select: 1=MDR, 0=ALUOut
- reg_dst  out  1  destination select: 1=rd, 0=rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=R-type (funct decode), 10=subtract; 11 never driven
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each legal instruction
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- Reset: async to FETCH. While rst_n=0, all outputs are forced to 0, including mem_read and mem_write, even mid-access.
- First cycle after release is FETCH. Reset during any state aborts the instruction; no partial write-back occurs.
- Outputs are decoded combinationally from state. Outputs qualified by mem_ready are noted per state. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - If mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE. Otherwise stay in FETCH with ir_write=0 and pc_write=0.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Opcode dispatch: 000000 to EXECUTE; 100011 (lw) or 101011 (sw) to MEM_ADDR; 000100 (beq) to BRANCH; 000010 (j) to JUMP.
  - Any other opcode: illegal_op=1, go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEM_READ; sw goes to MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1, go to FETCH.
- MEM_WRITE: mem_write=1, iord=1. Hold until mem_ready=1; in that cycle instr_done=1, then go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=01, go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=10, pc_write_cond=1, pc_source=01, instr_done=1, go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1, go to FETCH.
- Latency, counted as cycles from FETCH entry to the next FETCH entry with mem_ready tied to 1:
  - lw 5, sw 4, R-type 4, beq 3, j 3.
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Unused state encodings fall to FETCH.

Optional Feature:
- Macro: MC_CTRL_ADDI_EN.
- Defined: opcode 001000 (addi) dispatches from DECODE to ADDI_EX, then ADDI_WB, then FETCH; latency 4.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
- Undefined: opcode 001000 is illegal (illegal_op pulse, return to FETCH), and the ADDI states do not exist.

Decomposition:
- Package mc_ctrl_pkg contains:
  - State enum (4-bit): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
  - Opcode constants.
  - alu_op constants (ALUOP_ADD, ALUOP_FUNCT, ALUOP_SUB), shared with the ALU control block.
- One sub-module, mc_ctrl_decode: a purely combinational state-to-outputs decoder. The top module keeps the state register and next-state logic.

Test Plan:
- Reset asserted mid-MEM_WRITE with mem_write=1: mem_write drops to 0 asynchronously; after release the FSM is in FETCH and mem_read=1.
- R-type (opcode 000000), mem_ready=1: states FETCH, DECODE, EXECUTE, R_WB; alu_op=01 in EXECUTE; reg_write=1 and reg_dst=1 only in R_WB; instr_done at cycle 4.
- lw (100011) with mem_ready low 2 cycles in MEM_READ: mem_read and iord held high for 3 cycles, then MEM_WB with mem_to_reg=1; total 7 cycles.
- beq (000100): BRANCH has alu_op=10, pc_write_cond=1, pc_source=01; 3 cycles; no reg_write at any point.
- FETCH with mem_ready=0 for 3 cycles: ir_write and pc_write stay 0, mem_read stays 1; in the 4th cycle (mem_ready=1) both pulse for one cycle.
- Opcode 001000: with MC_CTRL_ADDI_EN, 4-cycle sequence ending in reg_write=1, reg_dst=0; without it, illegal_op pulses in DECODE, no instr_done, return to FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle main control FSM: state encoding, opcodes, ALU-op codes.
// MC_CTRL_ADDI_EN adds the ADDI_EX/ADDI_WB states and makes opcode 001000 legal.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
`ifdef MC_CTRL_ADDI_EN
    ,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Codes consumed by the downstream ALU control block.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_out_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ) || (op == OP_J);
`ifdef MC_CTRL_ADDI_EN
    legal = legal || (op == OP_ADDI);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control bundle between the main control FSM (master) and the datapath/memory (slave).
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-strobe decoder; i_out_en low forces every strobe to 0.
// MC_CTRL_ADDI_EN adds decode for the ADDI states.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_out_en,
  output ctrl_out_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      DECODE: begin
        o_ctrl.alu_src_b  = 2'b11;
        o_ctrl.alu_op     = ALUOP_ADD;
        o_ctrl.illegal_op = ~op_is_legal(i_opcode);
      end
      MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = 2'b01;
        o_ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = 2'b10;
        o_ctrl.instr_done = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
`endif
      default: o_ctrl = '0;
    endcase
    // Gating with reset keeps memory strobes quiet even mid-access.
    if (!i_out_en) o_ctrl = '0;
  end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register and next-state logic; strobes come from mc_ctrl_decode.
// MC_CTRL_ADDI_EN enables the addi path (DECODE -> ADDI_EX -> ADDI_WB).
module mc_main_control
  import mc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mc_main_control_if.master  ctrl
);

  state_e    r_state;
  state_e    w_state_next;
  ctrl_out_t w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = FETCH;
    case (r_state)
      FETCH:     w_state_next = ctrl.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (ctrl.opcode)
          OP_RTYPE:     w_state_next = EXECUTE;
          OP_LW, OP_SW: w_state_next = MEM_ADDR;
          OP_BEQ:       w_state_next = BRANCH;
          OP_J:         w_state_next = JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      w_state_next = ADDI_EX;
`endif
          default:      w_state_next = FETCH;
        endcase
      end
      // Only lw and sw reach MEM_ADDR, so anything other than lw is a store.
      MEM_ADDR:  w_state_next = (ctrl.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  w_state_next = ctrl.mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: w_state_next = ctrl.mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   w_state_next = R_WB;
`ifdef MC_CTRL_ADDI_EN
      ADDI_EX:   w_state_next = ADDI_WB;
`endif
      default:   w_state_next = FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (ctrl.opcode),
    .i_mem_ready (ctrl.mem_ready),
    .i_out_en    (rst_n),
    .o_ctrl      (w_ctrl)
  );

  assign ctrl.pc_write      = w_ctrl.pc_write;
  assign ctrl.pc_write_cond = w_ctrl.pc_write_cond;
  assign ctrl.iord          = w_ctrl.iord;
  assign ctrl.mem_read      = w_ctrl.mem_read;
  assign ctrl.mem_write     = w_ctrl.mem_write;
  assign ctrl.ir_write      = w_ctrl.ir_write;
  assign ctrl.mem_to_reg    = w_ctrl.mem_to_reg;
  assign ctrl.reg_dst       = w_ctrl.reg_dst;
  assign ctrl.reg_write     = w_ctrl.reg_write;
  assign ctrl.alu_src_a     = w_ctrl.alu_src_a;
  assign ctrl.alu_src_b     = w_ctrl.alu_src_b;
  assign ctrl.alu_op        = w_ctrl.alu_op;
  assign ctrl.pc_source     = w_ctrl.pc_source;
  assign ctrl.instr_done    = w_ctrl.instr_done;
  assign ctrl.illegal_op    = w_ctrl.illegal_op;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-cycle vector table plus reset and stall sequences.
module tb_mc_main_control;

  // Output word order: pw pwc iord mr mw irw m2r rdst rw asa asb[1:0] aop[1:0] psrc[1:0] done ill
  localparam logic [17:0] E_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] E_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] E_MADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_MREAD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MWB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_MWR_W   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MWR_R   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] E_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_01_00_0_0;
  localparam logic [17:0] E_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] E_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_10_01_1_0;
  localparam logic [17:0] E_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] E_ADDI_WB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [17:0] exp;
    string       tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  logic [17:0] act;

  mc_main_control_if bus ();

  mc_main_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus.master)
  );

  always #5 clk = ~clk;

  assign act = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op};

  task automatic check(input string name, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end else begin
      $display("ok   %s outputs=%b", name, act);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [17:0] exp, input string tag);
    vec_t v;
    v.op = op; v.rdy = rdy; v.exp = exp; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic [5:0] op, input logic rdy, input logic [17:0] exp, input string tag);
    @(negedge clk);
    bus.opcode = op;
    bus.mem_ready = rdy;
    #1;
    check(tag, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // R-type, 4 cycles
    add(6'b000000, 1'b1, E_FETCH_R, "rt_fetch");
    add(6'b000000, 1'b1, E_DECODE,  "rt_decode");
    add(6'b000000, 1'b1, E_EXEC,    "rt_execute");
    add(6'b000000, 1'b1, E_RWB,     "rt_wb");
    // lw with two wait cycles in MEM_READ, 7 cycles
    add(6'b100011, 1'b1, E_FETCH_R, "lw_fetch");
    add(6'b100011, 1'b1, E_DECODE,  "lw_decode");
    add(6'b100011, 1'b1, E_MADDR,   "lw_addr");
    add(6'b100011, 1'b0, E_MREAD,   "lw_read_wait1");
    add(6'b100011, 1'b0, E_MREAD,   "lw_read_wait2");
    add(6'b100011, 1'b1, E_MREAD,   "lw_read_done");
    add(6'b100011, 1'b1, E_MWB,     "lw_wb");
    // sw, 4 cycles
    add(6'b101011, 1'b1, E_FETCH_R, "sw_fetch");
    add(6'b101011, 1'b1, E_DECODE,  "sw_decode");
    add(6'b101011, 1'b1, E_MADDR,   "sw_addr");
    add(6'b101011, 1'b1, E_MWR_R,   "sw_write");
    // beq, mem_ready low outside memory states must be ignored
    add(6'b000100, 1'b1, E_FETCH_R, "beq_fetch");
    add(6'b000100, 1'b0, E_DECODE,  "beq_decode");
    add(6'b000100, 1'b0, E_BRANCH,  "beq_branch");
    // j
    add(6'b000010, 1'b1, E_FETCH_R, "j_fetch");
    add(6'b000010, 1'b1, E_DECODE,  "j_decode");
    add(6'b000010, 1'b1, E_JUMP,    "j_jump");
    // FETCH stalled 3 cycles then R-type
    add(6'b000000, 1'b0, E_FETCH_W, "stall_fetch1");
    add(6'b000000, 1'b0, E_FETCH_W, "stall_fetch2");
    add(6'b000000, 1'b0, E_FETCH_W, "stall_fetch3");
    add(6'b000000, 1'b1, E_FETCH_R, "stall_fetch4");
    add(6'b000000, 1'b1, E_DECODE,  "stall_decode");
    add(6'b000000, 1'b1, E_EXEC,    "stall_execute");
    add(6'b000000, 1'b1, E_RWB,     "stall_wb");
    // unsupported opcode
    add(6'b111111, 1'b1, E_FETCH_R, "ill_fetch");
    add(6'b111111, 1'b1, E_DEC_ILL, "ill_decode");
    // addi
    add(6'b001000, 1'b1, E_FETCH_R, "addi_fetch");
`ifdef MC_CTRL_ADDI_EN
    add(6'b001000, 1'b1, E_DECODE,  "addi_decode");
    add(6'b001000, 1'b1, E_MADDR,   "addi_ex");
    add(6'b001000, 1'b1, E_ADDI_WB, "addi_wb");
`else
    add(6'b001000, 1'b1, E_DEC_ILL, "addi_decode_illegal");
`endif
    add(6'b000010, 1'b1, E_FETCH_R, "post_fetch");
    add(6'b000010, 1'b1, E_DECODE,  "post_decode");
    add(6'b000010, 1'b1, E_JUMP,    "post_jump");

    // Reset held: strobes forced low even with mem_ready high
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", E_ZERO);

    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("reset_release_fetch", E_FETCH_W);

    foreach (vecs[i]) apply(vecs[i].op, vecs[i].rdy, vecs[i].exp, vecs[i].tag);

    // Reset in the middle of a stalled store
    apply(6'b101011, 1'b1, E_FETCH_R, "rst_sw_fetch");
    apply(6'b101011, 1'b1, E_DECODE,  "rst_sw_decode");
    apply(6'b101011, 1'b1, E_MADDR,   "rst_sw_addr");
    apply(6'b101011, 1'b0, E_MWR_W,   "rst_sw_write_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_write_async", E_ZERO);
    @(negedge clk);
    #1;
    check("rst_mid_write_held", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("rst_mid_write_release", E_FETCH_W);
    apply(6'b000000, 1'b1, E_FETCH_R, "rst_after_fetch");
    apply(6'b000000, 1'b1, E_DECODE,  "rst_after_decode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
